// File: rtl/sensor_input_filter.sv
// Per-channel 2-FF synchronizer plus stability debounce for the irrigation field sensors.
// Optional per-channel chatter detection is built when CHATTER_DETECT_EN is defined.
module sensor_input_filter #(
  parameter int unsigned NUM_CH          = 6,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CHATTER_WINDOW  = 1000000,
  parameter int unsigned CHATTER_LIMIT   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] filtered_o,
  output logic [NUM_CH-1:0] change_o,
  output logic              valid_o,
  input  logic              clear_chatter_i,
  output logic [NUM_CH-1:0] chatter_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] s1_q, s1_d;
  logic [NUM_CH-1:0] s2_q, s2_d;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [NUM_CH-1:0] change_q, change_d;
  logic [NUM_CH-1:0] settled_q, settled_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  always_comb begin
    s1_d      = raw_i;
    s2_d      = s1_q;
    filt_d    = filt_q;
    change_d  = '0;
    settled_d = settled_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (s1_q[ch] != s2_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] != CntMax) begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
      // s2 has been stable for the full window, so commit it even if s1 just moved.
      if (cnt_q[ch] == CntMax) begin
        filt_d[ch]    = s2_q[ch];
        settled_d[ch] = 1'b1;
        change_d[ch]  = settled_q[ch] & (s2_q[ch] != filt_q[ch]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      filt_q    <= '0;
      change_q  <= '0;
      settled_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      filt_q    <= filt_d;
      change_q  <= change_d;
      settled_q <= settled_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign filtered_o = filt_q;
  assign change_o   = change_q;
  assign valid_o    = &settled_q;

`ifdef CHATTER_DETECT_EN
  localparam int unsigned WinW  = (CHATTER_WINDOW > 2) ? $clog2(CHATTER_WINDOW) : 1;
  localparam int unsigned EdgeW = $clog2(CHATTER_LIMIT + 1);
  localparam logic [WinW-1:0]  WinMax = WinW'(CHATTER_WINDOW - 1);
  localparam logic [EdgeW-1:0] EdgeLim = EdgeW'(CHATTER_LIMIT);

  logic [WinW-1:0]   win_q, win_d;
  logic              wrap;
  logic [EdgeW-1:0]  edge_q [NUM_CH];
  logic [EdgeW-1:0]  edge_d [NUM_CH];
  logic [NUM_CH-1:0] chat_q, chat_d;

  always_comb begin
    wrap   = (win_q == WinMax);
    win_d  = wrap ? '0 : win_q + 1'b1;
    chat_d = clear_chatter_i ? '0 : chat_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      edge_d[ch] = edge_q[ch];
      if (wrap) begin
        edge_d[ch] = EdgeW'(s1_q[ch] ^ s2_q[ch]);
      end else if ((s1_q[ch] != s2_q[ch]) && (edge_q[ch] != EdgeLim)) begin
        edge_d[ch] = edge_q[ch] + 1'b1;
      end
      // Flag on reaching the limit only, so a clear is not immediately overridden.
      if ((edge_d[ch] == EdgeLim) && (edge_q[ch] != EdgeLim)) begin
        chat_d[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      win_q  <= '0;
      chat_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        edge_q[ch] <= '0;
      end
    end else begin
      win_q  <= win_d;
      chat_q <= chat_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        edge_q[ch] <= edge_d[ch];
      end
    end
  end

  assign chatter_o = chat_q;
`else
  logic unused_clear_chatter;
  assign unused_clear_chatter = clear_chatter_i;
  assign chatter_o = '0;
`endif

endmodule

// File: tb/tb_sensor_input_filter.sv
// Directed bench for sensor_input_filter with DEBOUNCE_CYCLES=4, window 32, limit 3.
module tb_sensor_input_filter;

  localparam int unsigned NumCh = 6;

  logic             clk;
  logic             rst_n;
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] filtered;
  logic [NumCh-1:0] change;
  logic             valid;
  logic             clear_chatter;
  logic [NumCh-1:0] chatter;

  int total;
  int bad;

  sensor_input_filter #(
    .NUM_CH         (NumCh),
    .CNT_W          (8),
    .DEBOUNCE_CYCLES(4),
    .CHATTER_WINDOW (32),
    .CHATTER_LIMIT  (3)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .raw_i          (raw),
    .filtered_o     (filtered),
    .change_o       (change),
    .valid_o        (valid),
    .clear_chatter_i(clear_chatter),
    .chatter_o      (chatter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw = '0;
    clear_chatter = 1'b0;
    step(1);
    total++;
    if (filtered !== 6'b0 || change !== 6'b0 || valid !== 1'b0 || chatter !== 6'b0) begin
      $display("FAIL reset_state: filt=%b chg=%b valid=%b chat=%b want all 0",
               filtered, change, valid, chatter);
      bad++;
    end
    rst_n = 1'b1;
    step(3);
    total++;
    if (valid !== 1'b0) begin
      $display("FAIL reset_valid_early: valid=%b want 0 after 3 edges", valid);
      bad++;
    end
    step(1);
    total++;
    if (valid !== 1'b1 || filtered !== 6'b0 || change !== 6'b0) begin
      $display("FAIL reset_valid_4: valid=%b filt=%b chg=%b want 1/000000/000000",
               valid, filtered, change);
      bad++;
    end
  endtask

  task automatic test_step_latency();
    raw[0] = 1'b1;
    step(5);
    total++;
    if (filtered !== 6'b000000 || change !== 6'b0) begin
      $display("FAIL step_early: filt=%b chg=%b want 000000/000000", filtered, change);
      bad++;
    end
    step(1);
    total++;
    if (filtered !== 6'b000001 || change !== 6'b000001) begin
      $display("FAIL step_commit: filt=%b chg=%b want 000001/000001", filtered, change);
      bad++;
    end
    step(1);
    total++;
    if (filtered !== 6'b000001 || change !== 6'b0) begin
      $display("FAIL step_pulse_end: filt=%b chg=%b want 000001/000000", filtered, change);
      bad++;
    end
  endtask

  task automatic test_short_pulse();
    int errs;
    errs = 0;
    raw[2] = 1'b1;
    step(3);
    raw[2] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (filtered !== 6'b000001 || change !== 6'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      $display("FAIL short_pulse: filt=%b chg=%b bad_cycles=%0d want 000001/000000",
               filtered, change, errs);
      bad++;
    end
  endtask

  task automatic toggle_ch1(input int cycles, output int errs);
    errs = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i % 2 == 0) raw[1] = ~raw[1];
      step(1);
      if (filtered[1] !== 1'b0 || change[1] !== 1'b0) errs++;
    end
  endtask

  task automatic test_chatter();
    int errs;
    logic [NumCh-1:0] exp_chat;
    toggle_ch1(20, errs);
    total++;
    if (errs != 0) begin
      $display("FAIL chatter_frozen: filt=%b bad_cycles=%0d want bit1 0", filtered, errs);
      bad++;
    end
`ifdef CHATTER_DETECT_EN
    exp_chat = 6'b000010;
`else
    exp_chat = 6'b000000;
`endif
    total++;
    if (chatter !== exp_chat) begin
      $display("FAIL chatter_set: chat=%b want %b", chatter, exp_chat);
      bad++;
    end
    raw[1] = 1'b0;
    step(8);
    clear_chatter = 1'b1;
    step(1);
    clear_chatter = 1'b0;
    total++;
    if (chatter !== 6'b0) begin
      $display("FAIL chatter_clear: chat=%b want 000000", chatter);
      bad++;
    end
    toggle_ch1(48, errs);
    total++;
    if (chatter !== exp_chat || errs != 0) begin
      $display("FAIL chatter_rearm: chat=%b bad_cycles=%0d want %b", chatter, errs, exp_chat);
      bad++;
    end
    raw[1] = 1'b0;
    step(10);
    total++;
    if (filtered !== 6'b000001 || change !== 6'b0) begin
      $display("FAIL chatter_after: filt=%b chg=%b want 000001/000000", filtered, change);
      bad++;
    end
  endtask

  task automatic test_simultaneous();
    raw[3] = 1'b1;
    raw[5] = 1'b1;
    step(5);
    total++;
    if (filtered !== 6'b000001 || change !== 6'b0) begin
      $display("FAIL simul_early: filt=%b chg=%b want 000001/000000", filtered, change);
      bad++;
    end
    step(1);
    total++;
    if (filtered !== 6'b101001 || change !== 6'b101000) begin
      $display("FAIL simul_commit: filt=%b chg=%b want 101001/101000", filtered, change);
      bad++;
    end
    step(1);
    total++;
    if (change !== 6'b0 || valid !== 1'b1) begin
      $display("FAIL simul_end: chg=%b valid=%b want 000000/1", change, valid);
      bad++;
    end
  endtask

  task automatic test_mid_reset();
    raw[4] = 1'b1;
    step(4);
    rst_n = 1'b0;
    raw = '0;
    step(1);
    total++;
    if (filtered !== 6'b0 || change !== 6'b0 || valid !== 1'b0 || chatter !== 6'b0) begin
      $display("FAIL mid_reset: filt=%b chg=%b valid=%b chat=%b want all 0",
               filtered, change, valid, chatter);
      bad++;
    end
    rst_n = 1'b1;
    step(3);
    total++;
    if (valid !== 1'b0) begin
      $display("FAIL mid_reset_valid_early: valid=%b want 0", valid);
      bad++;
    end
    step(1);
    total++;
    if (valid !== 1'b1 || filtered !== 6'b0 || change !== 6'b0) begin
      $display("FAIL mid_reset_requal: valid=%b filt=%b chg=%b want 1/000000/000000",
               valid, filtered, change);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    raw = '0;
    clear_chatter = 1'b0;
    #2;
    test_reset();
    test_step_latency();
    test_short_pulse();
    test_chatter();
    test_simultaneous();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
